// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Purpose  : Shared encodings for the multi-cycle MIPS sequencer.
// Revision : 1.0
// ============================================================================
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd8;
  localparam logic [3:0] ALU_LUI  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SLLV = 4'd11;

  localparam logic [3:0] NPC_PC4    = 4'd0;
  localparam logic [3:0] NPC_BRANCH = 4'd1;
  localparam logic [3:0] NPC_JUMP   = 4'd2;
  localparam logic [3:0] NPC_JR     = 4'd3;
  localparam logic [3:0] NPC_JALR   = 4'd4;

  localparam logic [1:0] GPR_RD = 2'd0;
  localparam logic [1:0] GPR_RT = 2'd1;
  localparam logic [1:0] GPR_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // Instruction classes are one-hot; branch_ne only qualifies branch.
  typedef struct packed {
    logic rtype;
    logic itype_alu;
    logic lw;
    logic sw;
    logic branch;
    logic branch_ne;
    logic j;
    logic jal;
    logic jr;
    logic jalr;
    logic illegal;
  } iclass_t;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_decode
// Purpose  : Static Op/Funct decode into instruction class and ALU controls.
// Revision : 1.0
// ============================================================================
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output iclass_t    cls,
  output logic [3:0] alu_op,
  output logic       alu_src,
  output logic       ext_op
);

  always_comb begin
    cls     = '0;
    alu_op  = ALU_NOP;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    case (Op)
      OP_RTYPE: begin
        cls.rtype = 1'b1;
        case (Funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SLLV:         alu_op = ALU_SLLV;
          FN_JR: begin
            cls.rtype = 1'b0;
            cls.jr    = 1'b1;
          end
          FN_JALR: begin
            cls.rtype = 1'b0;
            cls.jalr  = 1'b1;
          end
          default: begin
            cls.rtype   = 1'b0;
            cls.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        cls.itype_alu = 1'b1;
        alu_op        = ALU_ADD;
        alu_src       = 1'b1;
        ext_op        = 1'b1;
      end
      OP_ANDI: begin
        cls.itype_alu = 1'b1;
        alu_op        = ALU_AND;
        alu_src       = 1'b1;
        ext_op        = 1'b1;
      end
      OP_ORI: begin
        cls.itype_alu = 1'b1;
        alu_op        = ALU_OR;
        alu_src       = 1'b1;
      end
      OP_SLTI: begin
        cls.itype_alu = 1'b1;
        alu_op        = ALU_SLT;
        alu_src       = 1'b1;
        ext_op        = 1'b1;
      end
      OP_LUI: begin
        cls.itype_alu = 1'b1;
        alu_op        = ALU_LUI;
        alu_src       = 1'b1;
      end
      OP_LW: begin
        cls.lw  = 1'b1;
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
      OP_SW: begin
        cls.sw  = 1'b1;
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
      OP_BEQ: begin
        cls.branch = 1'b1;
        alu_op     = ALU_SUB;
      end
      OP_BNE: begin
        cls.branch    = 1'b1;
        cls.branch_ne = 1'b1;
        alu_op        = ALU_SUB;
      end
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle MIPS sequencer with memory handshake and watchdog.
// Revision : 1.0
// ============================================================================
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       EXTOp,
  output logic       ALUSrc,
  output logic [3:0] ALUOp,
  output logic [3:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [2:0] state,
  output logic       illegal,
  output logic       mem_err
);

  state_e        state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;

  iclass_t    w_cls;
  logic [3:0] w_dec_alu_op;
  logic       w_dec_alu_src, w_dec_ext_op;
  logic       w_timeout;

  logic       w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write, w_reg_write;
  logic       w_ext_op, w_alu_src, w_illegal, w_mem_err;
  logic [3:0] w_alu_op, w_npc_op;
  logic [1:0] w_gpr_sel, w_wd_sel;

  mc_decode u_decode (
    .Op      (Op),
    .Funct   (Funct),
    .cls     (w_cls),
    .alu_op  (w_dec_alu_op),
    .alu_src (w_dec_alu_src),
    .ext_op  (w_dec_ext_op)
  );

  // Only consulted in IF/MEM; a same-cycle mem_ready beats the watchdog.
  assign w_timeout = (wait_q == TW'(TIMEOUT)) && !mem_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_iord      = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_ext_op    = 1'b0;
    w_alu_src   = 1'b0;
    w_alu_op    = ALU_NOP;
    w_npc_op    = NPC_PC4;
    w_gpr_sel   = GPR_RD;
    w_wd_sel    = WD_ALU;
    w_illegal   = 1'b0;
    w_mem_err   = 1'b0;

    case (state_q)
      S_IF: begin
        if (w_timeout) begin
          w_mem_err = 1'b1;
          wait_d    = '0;
        end else begin
          w_mem_read = 1'b1;
          if (mem_ready) begin
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
            w_npc_op   = NPC_PC4;
            state_d    = S_ID;
          end else begin
            wait_d = wait_q + TW'(1);
          end
        end
      end

      S_ID: begin
        state_d = S_IF;
        if (w_cls.j) begin
          w_pc_write = 1'b1;
          w_npc_op   = NPC_JUMP;
        end else if (w_cls.jal) begin
          w_pc_write  = 1'b1;
          w_npc_op    = NPC_JUMP;
          w_reg_write = 1'b1;
          w_gpr_sel   = GPR_RA;
          w_wd_sel    = WD_PC;
        end else if (w_cls.jr) begin
          w_pc_write = 1'b1;
          w_npc_op   = NPC_JR;
        end else if (w_cls.jalr) begin
          w_pc_write  = 1'b1;
          w_npc_op    = NPC_JALR;
          w_reg_write = 1'b1;
          w_gpr_sel   = GPR_RD;
          w_wd_sel    = WD_PC;
        end else if (w_cls.illegal) begin
          w_illegal = 1'b1;
        end else if (w_cls.rtype | w_cls.itype_alu | w_cls.lw | w_cls.sw | w_cls.branch) begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        w_alu_op  = w_dec_alu_op;
        w_alu_src = w_dec_alu_src;
        w_ext_op  = w_dec_ext_op;
        if (w_cls.branch) begin
          state_d = S_IF;
          if (w_cls.branch_ne ? !Zero : Zero) begin
            w_pc_write = 1'b1;
            w_npc_op   = NPC_BRANCH;
          end
        end else if (w_cls.lw | w_cls.sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        if (w_timeout) begin
          w_mem_err = 1'b1;
          state_d   = S_IF;
        end else begin
          w_iord      = 1'b1;
          w_alu_op    = w_dec_alu_op;
          w_alu_src   = w_dec_alu_src;
          w_ext_op    = w_dec_ext_op;
          w_mem_read  = w_cls.lw;
          w_mem_write = w_cls.sw;
          if (mem_ready) begin
            state_d = w_cls.lw ? S_WB : S_IF;
          end else begin
            wait_d = wait_q + TW'(1);
          end
        end
      end

      S_WB: begin
        w_reg_write = 1'b1;
        w_alu_op    = w_dec_alu_op;
        w_alu_src   = w_dec_alu_src;
        w_ext_op    = w_dec_ext_op;
        w_gpr_sel   = (w_cls.itype_alu | w_cls.lw) ? GPR_RT : GPR_RD;
        w_wd_sel    = w_cls.lw ? WD_MEM : WD_ALU;
        state_d     = S_IF;
      end

      default: state_d = S_IF;
    endcase

    if (state_d != state_q) begin
      wait_d = '0;
    end
  end

  // Reset must suppress every strobe, including the IF fetch request.
  assign PCWrite  = rstn & w_pc_write;
  assign IRWrite  = rstn & w_ir_write;
  assign IorD     = rstn & w_iord;
  assign MemRead  = rstn & w_mem_read;
  assign MemWrite = rstn & w_mem_write;
  assign RegWrite = rstn & w_reg_write;
  assign EXTOp    = rstn & w_ext_op;
  assign ALUSrc   = rstn & w_alu_src;
  assign ALUOp    = rstn ? w_alu_op  : 4'd0;
  assign NPCOp    = rstn ? w_npc_op  : 4'd0;
  assign GPRSel   = rstn ? w_gpr_sel : 2'd0;
  assign WDSel    = rstn ? w_wd_sel  : 2'd0;
  assign illegal  = rstn & w_illegal;
  assign mem_err  = rstn & w_mem_err;
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Directed bench for mc_ctrl against a phase-list behavioural model.
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl;

  localparam int TIMEOUT = 15;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
  localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9, K_ILL = 10;
  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;

  logic       clk, rstn, Zero, mem_ready;
  logic [5:0] Op, Funct;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrc;
  logic [3:0] ALUOp, NPCOp;
  logic [1:0] GPRSel, WDSel;
  logic [2:0] state;
  logic       illegal, mem_err;

  int n_checks = 0;
  int n_err    = 0;

  mc_ctrl #(.TIMEOUT(TIMEOUT), .TW(4)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel), .state(state),
    .illegal(illegal), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction set as a lookup table: class plus the EX-stage ALU controls.
  function automatic void bdec(input logic [5:0] op, input logic [5:0] fn, output int k,
                               output logic [3:0] alu, output logic ext, output logic src);
    k = K_ILL; alu = 4'd0; ext = 1'b0; src = 1'b0;
    case (op)
      6'h00: begin
        k = K_R;
        case (fn)
          6'h20, 6'h21: alu = 4'd1;
          6'h22, 6'h23: alu = 4'd2;
          6'h24: alu = 4'd3;
          6'h25: alu = 4'd4;
          6'h2a: alu = 4'd5;
          6'h2b: alu = 4'd6;
          6'h00: alu = 4'd7;
          6'h27: alu = 4'd8;
          6'h02: alu = 4'd10;
          6'h04: alu = 4'd11;
          6'h08: k = K_JR;
          6'h09: k = K_JALR;
          default: k = K_ILL;
        endcase
      end
      6'h08: begin k = K_I;  alu = 4'd1; ext = 1'b1; src = 1'b1; end
      6'h0c: begin k = K_I;  alu = 4'd3; ext = 1'b1; src = 1'b1; end
      6'h0d: begin k = K_I;  alu = 4'd4; src = 1'b1; end
      6'h0a: begin k = K_I;  alu = 4'd5; ext = 1'b1; src = 1'b1; end
      6'h0f: begin k = K_I;  alu = 4'd9; src = 1'b1; end
      6'h23: begin k = K_LW; alu = 4'd1; ext = 1'b1; src = 1'b1; end
      6'h2b: begin k = K_SW; alu = 4'd1; ext = 1'b1; src = 1'b1; end
      6'h04: begin k = K_BEQ; alu = 4'd2; end
      6'h05: begin k = K_BNE; alu = 4'd2; end
      6'h02: k = K_J;
      6'h03: k = K_JAL;
      default: k = K_ILL;
    endcase
  endfunction

  // Each class walks a fixed list of phases; R/I skip MEM.
  function automatic int seq_len(input int k);
    case (k)
      K_R, K_I, K_SW: return 4;
      K_LW:           return 5;
      K_BEQ, K_BNE:   return 3;
      default:        return 2;
    endcase
  endfunction

  function automatic int phase_at(input int k, input int s);
    if ((k == K_R || k == K_I) && s == 3) return PH_W;
    return s;
  endfunction

  int         m_step = 0, m_wait = 0, m_kind, m_len, m_ph;
  logic [3:0] m_alu;
  logic       m_ext, m_src, m_tmo, m_done;
  logic       e_pcw, e_irw, e_iord, e_mrd, e_mwr, e_rw, e_ext, e_src, e_ill, e_merr;
  logic [3:0] e_alu, e_npc;
  logic [1:0] e_gpr, e_wd;
  logic [2:0] e_st;
  logic [24:0] v_exp, v_got;

  always @(negedge clk) begin
    {e_pcw, e_irw, e_iord, e_mrd, e_mwr, e_rw, e_ext, e_src, e_ill, e_merr} = '0;
    e_alu = 4'd0; e_npc = 4'd0; e_gpr = 2'd0; e_wd = 2'd0; e_st = 3'd0;
    if (!rstn) begin
      m_step = 0;
      m_wait = 0;
    end else begin
      bdec(Op, Funct, m_kind, m_alu, m_ext, m_src);
      m_len  = seq_len(m_kind);
      m_ph   = phase_at(m_kind, m_step);
      e_st   = 3'(m_ph);
      m_tmo  = (m_ph == PH_F || m_ph == PH_M) && (m_wait == TIMEOUT) && !mem_ready;
      m_done = 1'b1;
      if (m_tmo) begin
        e_merr = 1'b1;
      end else begin
        case (m_ph)
          PH_F: begin
            e_mrd  = 1'b1;
            m_done = mem_ready;
            if (mem_ready) begin e_irw = 1'b1; e_pcw = 1'b1; end
          end
          PH_D: begin
            case (m_kind)
              K_J:    begin e_pcw = 1'b1; e_npc = 4'd2; end
              K_JAL:  begin e_pcw = 1'b1; e_npc = 4'd2; e_rw = 1'b1; e_gpr = 2'd2; e_wd = 2'd2; end
              K_JR:   begin e_pcw = 1'b1; e_npc = 4'd3; end
              K_JALR: begin e_pcw = 1'b1; e_npc = 4'd4; e_rw = 1'b1; e_gpr = 2'd0; e_wd = 2'd2; end
              K_ILL:  e_ill = 1'b1;
              default: ;
            endcase
          end
          PH_E: begin
            e_alu = m_alu; e_ext = m_ext; e_src = m_src;
            if ((m_kind == K_BEQ && Zero) || (m_kind == K_BNE && !Zero)) begin
              e_pcw = 1'b1; e_npc = 4'd1;
            end
          end
          PH_M: begin
            e_iord = 1'b1; e_alu = m_alu; e_ext = m_ext; e_src = m_src;
            e_mrd  = (m_kind == K_LW);
            e_mwr  = (m_kind == K_SW);
            m_done = mem_ready;
          end
          default: begin
            e_rw  = 1'b1; e_alu = m_alu; e_ext = m_ext; e_src = m_src;
            e_gpr = (m_kind == K_I || m_kind == K_LW) ? 2'd1 : 2'd0;
            e_wd  = (m_kind == K_LW) ? 2'd1 : 2'd0;
          end
        endcase
      end
      if (m_tmo) begin
        m_step = 0; m_wait = 0;
      end else if (m_done) begin
        m_wait = 0;
        m_step = (m_step + 1 == m_len) ? 0 : m_step + 1;
      end else begin
        m_wait++;
      end
    end
    v_exp = {e_pcw, e_irw, e_iord, e_mrd, e_mwr, e_rw, e_ext, e_src, e_alu, e_npc,
             e_gpr, e_wd, e_st, e_ill, e_merr};
    v_got = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrc, ALUOp,
             NPCOp, GPRSel, WDSel, state, illegal, mem_err};
    n_checks++;
    if (v_got !== v_exp) begin
      n_err++;
      $display("FAIL cycle_model t=%0t got=%h exp=%h (pcw,irw,iord,mrd,mwr,rw,ext,src,alu,npc,gpr,wd,st,ill,merr)",
               $time, v_got, v_exp);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Runs one instruction from IF until the DUT is back in IF; mem_dly stalls MEM.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int mem_dly, input int exp_cyc);
    int cyc = 0;
    int mw  = 0;
    Op = op; Funct = fn; Zero = z;
    forever begin
      if (state == 3'd3) begin
        mem_ready = (mw >= mem_dly);
        mw++;
      end else begin
        mem_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (state == 3'd0 || cyc >= 40) break;
    end
    check(name, cyc, exp_cyc);
  endtask

  task automatic fetch_timeout(input bit ready_last);
    Op = 6'h00; Funct = 6'h20; Zero = 1'b0; mem_ready = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    if (ready_last) mem_ready = 1'b1;
    @(negedge clk);
    check(ready_last ? "race_mem_err" : "tmo_mem_err", int'(mem_err), ready_last ? 0 : 1);
    check(ready_last ? "race_irwrite" : "tmo_irwrite", int'(IRWrite), ready_last ? 1 : 0);
    @(posedge clk); #1;
    check(ready_last ? "race_state" : "tmo_state", int'(state), ready_last ? 1 : 0);
    if (ready_last) begin
      mem_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("race_add_done", int'(state), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rstn = 1'b0; Op = 6'h00; Funct = 6'h20; Zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_memread", int'(MemRead), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("first_fetch", int'(MemRead), 1);
    @(posedge clk); #1;

    run_instr("lat_add",      6'h00, 6'h20, 1'b0, 0, 4);
    run_instr("lat_ori",      6'h0d, 6'h00, 1'b0, 0, 4);
    run_instr("lat_sllv",     6'h00, 6'h04, 1'b0, 0, 4);
    run_instr("lat_slti",     6'h0a, 6'h00, 1'b0, 0, 4);
    run_instr("lat_lui",      6'h0f, 6'h00, 1'b0, 0, 4);
    run_instr("lat_lw_wait2", 6'h23, 6'h00, 1'b0, 2, 7);
    run_instr("lat_lw",       6'h23, 6'h00, 1'b0, 0, 5);
    run_instr("lat_sw",       6'h2b, 6'h00, 1'b0, 0, 4);
    run_instr("lat_sw_wait1", 6'h2b, 6'h00, 1'b0, 1, 5);
    run_instr("lat_beq_t",    6'h04, 6'h00, 1'b1, 0, 3);
    run_instr("lat_beq_nt",   6'h04, 6'h00, 1'b0, 0, 3);
    run_instr("lat_bne_t",    6'h05, 6'h00, 1'b0, 0, 3);
    run_instr("lat_bne_nt",   6'h05, 6'h00, 1'b1, 0, 3);
    run_instr("lat_j",        6'h02, 6'h00, 1'b0, 0, 2);
    run_instr("lat_jal",      6'h03, 6'h00, 1'b0, 0, 2);
    run_instr("lat_jr",       6'h00, 6'h08, 1'b0, 0, 2);
    run_instr("lat_jalr",     6'h00, 6'h09, 1'b0, 0, 2);
    run_instr("lat_ill_op",   6'h3f, 6'h00, 1'b0, 0, 2);
    run_instr("lat_ill_fn",   6'h00, 6'h3f, 1'b0, 0, 2);

    fetch_timeout(1'b0);
    fetch_timeout(1'b1);
    run_instr("lat_lw_memtmo", 6'h23, 6'h00, 1'b0, 20, 19);

    // Reset in the middle of a stalled sw.
    Op = 6'h2b; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("sw_in_mem", int'(state), 3);
    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_memwrite", int'(MemWrite), 0);
      check("rst_state_mid", int'(state), 0);
      check("rst_memread_mid", int'(MemRead), 0);
      @(posedge clk); #1;
    end
    rstn = 1'b1;
    @(negedge clk);
    check("release_fetch", int'(MemRead), 1);
    @(posedge clk); #1;

    run_instr("lat_add_end", 6'h00, 6'h20, 1'b0, 0, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath. It drives one shared ALU and one shared instruction/data memory port through IF/ID/EX/MEM/WB states, so an instruction takes 2–5+ cycles instead of one. It decodes the same instruction subset and uses the same ALUOp/NPCOp/GPRSel/WDSel encodings as the single-cycle decoder. It adds a memory ready handshake and a memory timeout watchdog.

Parameters:
TIMEOUT, 15, max cycles to wait for mem_ready in IF or MEM before aborting
TW, 4, width of wait counter; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
Op  in  6  opcode from instruction register (IR)
Funct  in  6  funct field from IR
Zero  in  1  ALU zero flag, valid in EX
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  PC load strobe
IRWrite  out  1  IR load strobe
IorD  out  1  memory address select: 0=PC, 1=ALU result register
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
RegWrite  out  1  register file write strobe
EXTOp  out  1  1=sign-extend immediate
ALUSrc  out  1  ALU B operand: 1=immediate
ALUOp  out  4  ALU operation: 1 add, 2 sub, 3 and, 4 or, 5 slt, 6 sltu, 7 sll, 8 nor, 9 lui, 10 srl, 11 sllv
NPCOp  out  4  next-PC select: 0 +4, 1 branch, 2 jump, 3 jr, 4 jalr
GPRSel  out  2  write register select: 0 rd, 1 rt, 2 $31
WDSel  out  2  write data select: 0 ALU, 1 MEM, 2 PC
state  out  3  current FSM state, for debug
illegal  out  1  one-cycle pulse in ID for an undecoded instruction
mem_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4. Binary encoded. Only `state` and the wait counter are registered; all strobes decode combinationally from state, Op, Funct, Zero and mem_ready.
- Reset: async on rstn low → state=S_IF, wait counter=0. While rstn is low every strobe (including MemRead) is forced to 0. The first fetch request is issued in the first cycle after rstn deasserts.
- Reset mid-instruction aborts it. No partial PC/IR/register/memory write may occur after rstn falls.
- S_IF:
  - Drives IorD=0, MemRead=1.
  - On mem_ready: IRWrite=1, PCWrite=1, NPCOp=0; go to S_ID.
  - Otherwise stay in S_IF and increment the wait counter.
- S_ID, by instruction class:
  - j: PCWrite=1, NPCOp=2 → S_IF.
  - jal: PCWrite=1, NPCOp=2, RegWrite=1, GPRSel=2, WDSel=2 → S_IF.
  - jr: PCWrite=1, NPCOp=3 → S_IF.
  - jalr: PCWrite=1, NPCOp=4, RegWrite=1, GPRSel=0, WDSel=2 → S_IF.
  - Undecoded: illegal=1, no writes, → S_IF (executes as a NOP).
  - All others → S_EX.
- S_EX:
  - ALUOp, ALUSrc and EXTOp follow the single-cycle decode (EXTOp=1 for addi, lw, sw, slti, andi).
  - beq/bne: ALUOp=2. PCWrite=1 with NPCOp=1 only when taken (beq&Zero or bne&~Zero). Go to S_IF whether taken or not.
  - lw/sw → S_MEM. Everything else → S_WB.
- S_MEM:
  - Drives IorD=1; MemRead=1 for lw, MemWrite=1 for sw. Both are held steady until mem_ready.
  - On mem_ready: lw → S_WB, sw → S_IF.
- S_WB:
  - RegWrite=1 for one cycle.
  - GPRSel=1 for I-type, 0 for R-type.
  - WDSel=1 for lw, 0 otherwise.
  - Go to S_IF.
- Wait counter:
  - Cleared on every state change.
  - Counts cycles spent in S_IF/S_MEM without mem_ready.
  - When it equals TIMEOUT and mem_ready is still 0: mem_err=1, all strobes 0, state → S_IF, counter cleared.
  - If mem_ready=1 in the same cycle the timeout is reached, mem_ready wins and no mem_err is raised.
- Latency with zero-wait memory: R-type/ALU-immediate 4 cycles, lw 5, sw 4, branch 3, jump 2.
- At most one of RegWrite/MemWrite/IRWrite is asserted in any cycle.

Decomposition:
- Package mc_pkg holds:
  - state encodings
  - ALUOp codes
  - NPCOp codes
  - GPRSel codes
  - WDSel codes
  - Op/Funct constants
- Sub-module mc_decode (combinational) converts Op/Funct to one-hot class signals (rtype, itype_alu, lw, sw, branch, j, jal, jr, jalr, illegal) plus static ALUOp/ALUSrc/EXTOp. The mc_ctrl FSM gates these by state.

Test Plan:
- rstn low for 3 cycles mid-S_MEM of sw → MemWrite=0 during reset, state=0, MemRead rises in the first cycle after release.
- add $3,$1,$2 with mem_ready tied 1 → states 0,1,2,4. RegWrite=1 only in cycle 4, with ALUOp=1, GPRSel=0, WDSel=0.
- lw with 2-cycle mem_ready delay in S_MEM → MemRead and IorD=1 held for 3 cycles. Then S_WB with WDSel=1, GPRSel=1; 7 cycles total.
- beq with Zero=1, then beq with Zero=0 → first: PCWrite=1, NPCOp=1 in S_EX. Second: PCWrite=0. Both return to S_IF after 3 cycles.
- jal then jalr → jal: single S_ID cycle with PCWrite, NPCOp=2, RegWrite, GPRSel=2, WDSel=2. jalr: NPCOp=4, GPRSel=0.
- mem_ready held 0 in S_IF with TIMEOUT=15 → mem_err pulses on the 16th cycle and state stays S_IF. A repeat where mem_ready rises exactly on that cycle → no mem_err and IRWrite=1.
